// File: rtl/cpu_params_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_params_pkg
//  Purpose  : Shared numeric parameters for the RisKy1 core. Holds the
//             default pipeline flush length, the flush counter width and a
//             saturating-increment helper.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_params_pkg;

    // Default number of cycles pipe_flush is held for each accepted redirect
    localparam int PIPE_FLUSH_CYCLES = 2;

    // Flush counter width; this width covers the legal FLUSH_CYCLES range 1..15
    localparam int PCTRL_CNT_W = 4;

    // 32-bit increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] pctrl_sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_structs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_structs_pkg
//  Purpose  : Shared type definitions for the RisKy1 core. Holds the
//             pipeline halt/flush sequencer state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_structs_pkg;

    // Halt/flush sequencer states, with an explicit 2-bit encoding
    typedef enum logic [1:0] {
        PCTRL_RUN    = 2'd0,
        PCTRL_FLUSH  = 2'd1,
        PCTRL_DRAIN  = 2'd2,
        PCTRL_HALTED = 2'd3
    } PCTRL_STATE_T;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Pipeline halt/flush sequencer. Turns trap and mispredict
//             redirects and debug halt requests into the pipe_flush and
//             cpu_halt controls. It also issues a one-cycle PC redirect to
//             Fetch. All outputs are registered.
//  Options  : PIPE_CTRL_PERF_EN - adds saturating counters for accepted
//             events, halted cycles and events ignored while halted.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;
#(
    parameter int PC_SZ        = 32,
    parameter int NUM_STAGES   = 5,
    parameter int FLUSH_CYCLES = PIPE_FLUSH_CYCLES
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  trap_in,
    input  logic [PC_SZ-1:0]      trap_pc_in,
    input  logic                  mispredict_in,
    input  logic [PC_SZ-1:0]      mispredict_pc_in,
    input  logic                  halt_req_in,
    input  logic [NUM_STAGES-1:0] stage_busy_in,
    output logic                  pipe_flush,
    output logic                  cpu_halt,
    output logic                  redirect_valid,
    output logic [PC_SZ-1:0]      redirect_pc,
    output logic                  halted_out
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]           flush_cnt_out,
    output logic [31:0]           halt_cyc_out,
    output logic [31:0]           err_cnt_out
`endif
);

    // Counter reload value: the first FLUSH cycle already counts as one cycle
    localparam logic [PCTRL_CNT_W-1:0] C_CNT_LOAD = PCTRL_CNT_W'(FLUSH_CYCLES - 1);

    PCTRL_STATE_T           r_state;
    PCTRL_STATE_T           w_state_nxt;
    logic [PCTRL_CNT_W-1:0] r_cnt;
    logic [PCTRL_CNT_W-1:0] w_cnt_nxt;
    logic [PC_SZ-1:0]       w_pc_nxt;
    logic                   w_event;
    logic                   w_accept;
    logic                   w_ignored;
    logic                   w_flush_nxt;
    logic                   w_halt_nxt;
    logic                   w_halted_nxt;

    assign w_event = trap_in | mispredict_in;

    // State register, flush counter and captured redirect target
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state     <= PCTRL_RUN;
            r_cnt       <= '0;
            redirect_pc <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            redirect_pc <= w_pc_nxt;
        end
    end

    // Next-state logic; trap outranks mispredict, which outranks halt
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pc_nxt    = redirect_pc;
        w_accept    = 1'b0;
        w_ignored   = 1'b0;
        case (r_state)
            PCTRL_RUN: begin
                if (w_event) begin
                    w_accept = 1'b1;
                end else if (halt_req_in) begin
                    w_state_nxt = PCTRL_DRAIN;
                end
            end
            PCTRL_FLUSH: begin
                // A mispredict here comes from a squashed instruction, so drop it
                if (trap_in) begin
                    w_accept = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt = halt_req_in ? PCTRL_DRAIN : PCTRL_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            PCTRL_DRAIN: begin
                // A pending halt survives a flush; halt_req_in is re-checked on exit
                if (w_event) begin
                    w_accept = 1'b1;
                end else if (!halt_req_in) begin
                    w_state_nxt = PCTRL_RUN;
                end else if (stage_busy_in == '0) begin
                    w_state_nxt = PCTRL_HALTED;
                end
            end
            PCTRL_HALTED: begin
                w_ignored = w_event;
                if (!halt_req_in) begin
                    w_state_nxt = PCTRL_RUN;
                end
            end
            default: begin
                w_state_nxt = PCTRL_RUN;
            end
        endcase
        if (w_accept) begin
            w_state_nxt = PCTRL_FLUSH;
            w_cnt_nxt   = C_CNT_LOAD;
            w_pc_nxt    = trap_in ? trap_pc_in : mispredict_pc_in;
        end
    end

    // Output decode from the next state, so outputs can be registered
    always_comb begin
        w_flush_nxt  = (w_state_nxt == PCTRL_FLUSH);
        w_halt_nxt   = (w_state_nxt == PCTRL_DRAIN) || (w_state_nxt == PCTRL_HALTED);
        w_halted_nxt = (w_state_nxt == PCTRL_HALTED);
    end

    // Output registers; the redirect pulse marks each accepted event
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            pipe_flush     <= 1'b0;
            cpu_halt       <= 1'b0;
            redirect_valid <= 1'b0;
            halted_out     <= 1'b0;
        end else begin
            pipe_flush     <= w_flush_nxt;
            cpu_halt       <= w_halt_nxt;
            redirect_valid <= w_accept;
            halted_out     <= w_halted_nxt;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Saturating performance counters
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            flush_cnt_out <= '0;
            halt_cyc_out  <= '0;
            err_cnt_out   <= '0;
        end else begin
            if (w_accept)  flush_cnt_out <= pctrl_sat_inc(flush_cnt_out);
            if (cpu_halt)  halt_cyc_out  <= pctrl_sat_inc(halt_cyc_out);
            if (w_ignored) err_cnt_out   <= pctrl_sat_inc(err_cnt_out);
        end
    end
`else
    // The ignored-event flag only drives the optional error counter
    logic w_unused;
    assign w_unused = w_ignored;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline halt/flush sequencer for the 5-stage RisKy1 core. It receives redirect events (trap, branch misprediction) from the Execute side and debug halt requests. It then drives the shared `pipe_flush` and `cpu_halt` controls consumed by Fetch and Decode, and issues a one-cycle PC redirect to Fetch. The block is the single owner of these signals; no stage generates them locally.

## Interface
- `PC_SZ`, 32, width of program counter
- `NUM_STAGES`, 5, number of stage-occupancy bits monitored
- `FLUSH_CYCLES`, 2, cycles `pipe_flush` is held per event; legal range 1..15
- `clk_in`  input  1  clock; all state changes on rising edge
- `reset_in`  input  1  asynchronous, active-low reset (0 = reset)
- `trap_in`  input  1  trap/exception redirect request, one-cycle pulse
- `trap_pc_in`  input  PC_SZ  trap vector target
- `mispredict_in`  input  1  branch misprediction redirect, one-cycle pulse
- `mispredict_pc_in`  input  PC_SZ  corrected target
- `halt_req_in`  input  1  debug halt request, level; deassert to resume
- `stage_busy_in`  input  NUM_STAGES  per-stage valid/occupied flags
- `pipe_flush`  output  1  flush Fetch/Decode pipeline registers
- `cpu_halt`  output  1  block new input into Decode
- `redirect_valid`  output  1  one-cycle pulse: Fetch loads `redirect_pc`
- `redirect_pc`  output  PC_SZ  redirect target
- `halted_out`  output  1  pipeline fully drained and stopped

## Operation
- FSM states: `RUN`, `FLUSH`, `DRAIN`, `HALTED`. Reset enters `RUN`. At reset all outputs are 0, `redirect_pc` = 0, and the flush counter = 0.
- Event priority in any state: `trap_in` > `mispredict_in` > `halt_req_in`.
- `RUN`:
  - On trap/mispredict, capture the target into `redirect_pc`, load the counter with FLUSH_CYCLES-1, and go to `FLUSH`.
  - Else, if `halt_req_in`, go to `DRAIN`.
- `FLUSH`:
  - `pipe_flush`=1 for every cycle in this state.
  - `redirect_valid`=1 only in the first `FLUSH` cycle.
  - The counter decrements each cycle.
  - When the counter is 0, exit:
    - to `DRAIN` if `halt_req_in`=1;
    - otherwise to `RUN`.
- Events arriving during `FLUSH`:
  - `mispredict_in` is ignored, because it comes from a squashed instruction.
  - `trap_in` recaptures the target, reloads the counter, and re-pulses `redirect_valid` in the next cycle.
- `DRAIN`:
  - `cpu_halt`=1.
  - On trap/mispredict, go to `FLUSH`. The halt stays pending because `halt_req_in` is re-evaluated on exit.
  - When `stage_busy_in`==0, go to `HALTED`.
  - If `halt_req_in` drops, go to `RUN`.
- `HALTED`:
  - `cpu_halt`=1 and `halted_out`=1.
  - When `halt_req_in`=0, go to `RUN`.
  - Trap/mispredict in `HALTED` is a protocol error: ignore it. With `PIPE_CTRL_PERF_EN`, count it in `err_cnt_out`.
- `cpu_halt` is 0 in `RUN` and `FLUSH`. Flush overrides halt in the stages anyway.

## Timing
- Event sampled at edge N: `pipe_flush` and `redirect_valid` are high from cycle N+1. `pipe_flush` is high for exactly FLUSH_CYCLES cycles.
- Simultaneous trap and mispredict: the trap target wins. `redirect_pc` never shows the mispredict target.
- `halt_req_in` rising in `RUN`: `cpu_halt`=1 at N+1.
- Busy zero sampled at edge M in `DRAIN`: `halted_out`=1 at M+1.
- `halt_req_in` falling in `HALTED`: `cpu_halt` and `halted_out` are 0 at the next cycle.
- All outputs are registered, with no combinational input-to-output paths.
- Reset asserted mid-`FLUSH` or mid-`DRAIN` clears all outputs immediately (asynchronous). There is no pending redirect after reset release.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: adds the following 32-bit saturating counters, cleared by reset:
  - `flush_cnt_out`: events accepted;
  - `halt_cyc_out`: cycles with `cpu_halt`=1;
  - `err_cnt_out`: events ignored in `HALTED`.
- Not defined: these ports and counters are absent, and functional behaviour is identical.

## Structure
- `PCTRL_STATE_T` enum goes in `cpu_structs_pkg`.
- Default `FLUSH_CYCLES` goes in `cpu_params_pkg` as constant `PIPE_FLUSH_CYCLES`.
- One module, no sub-module. The perf counters are a single generate-style `ifdef` region inside it.

## Test plan
- Mispredict pulse, PC=0x0000_0100, FLUSH_CYCLES=2 -> `pipe_flush` high 2 cycles; `redirect_valid` 1 cycle with `redirect_pc`=0x100; back to `RUN`.
- Trap (0x0000_0004) and mispredict (0x200) in the same cycle -> single redirect to 0x4.
- Trap 0x4, then trap 0x8 in the first `FLUSH` cycle -> second `redirect_valid` pulse with 0x8; `pipe_flush` extended to 3 cycles total.
- `halt_req_in`=1 with `stage_busy_in`=5'b00110, clearing after 4 cycles -> `cpu_halt` at N+1; `halted_out` one cycle after busy reaches 0.
- Mispredict during `DRAIN` with halt held -> `FLUSH` then back to `DRAIN`; `halted_out` only after flush completes and busy is 0.
- Reset low during `FLUSH` -> all outputs 0 immediately; `RUN` with no redirect after release.
